md6_hash_tx: RTL

UART transmitter that returns the MD6 digest to the host over `TxD`, the reverse path of the serial receiver that loads M, d, K, L, r, keylen and padding. When the digest is valid and the transmit button is pressed, it latches the digest and sends ceil(d/8) bytes as 8N1 frames. Byte order is most significant byte first; within each frame, bits go LSB first. It sits in `top` between the MD6 compression core and the `TxD` pin.

---
 rtl/md6_pkg.sv | 11 +
 rtl/md6_hash_tx_if.sv | 21 ++
 rtl/uart_tx_byte.sv | 96 +++++++++
 rtl/md6_hash_tx.sv | 99 +++++++++
 4 files changed

// File: rtl/md6_pkg.sv
// Shared types and constants for the MD6 digest UART return path.
package md6_pkg;
  localparam int MAX_D                = 512;
  localparam int DEFAULT_CLKS_PER_BIT = 10416;
  localparam int BYTE_IDX_W           = $clog2(MAX_D / 8);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} tx_state_t;

  // Byte sequencer phases in the top level; the serializer owns START/DATA/STOP.
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_SEND, SEQ_DONE} seq_state_t;
endpackage

// File: rtl/md6_hash_tx_if.sv
// Signals between the MD6 core / push button and the digest transmitter.
interface md6_hash_tx_if;
  import md6_pkg::*;

  logic             button_tx;
  logic             hash_valid;
  logic [MAX_D-1:0] hash;
  logic [9:0]       d;
  logic             TxD;
  logic             busy;
  logic             done_tx;

  // Handshakes: a transmit request is a synchronized rising edge of button_tx
  // seen while idle with hash_valid high; it is taken on that clock edge or
  // dropped. Internally, a byte moves to the serializer on the edge where
  // load and ready are both high; load is held until that edge.
  modport master (output button_tx, hash_valid, hash, d,
                  input  TxD, busy, done_tx);
  modport slave  (input  button_tx, hash_valid, hash, d,
                  output TxD, busy, done_tx);
endinterface

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer with load/ready handshake; chains bytes with no gap.
module uart_tx_byte
  import md6_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      load,
  input  logic [7:0] tx_byte,
  output logic      ready,
  output logic      txd,
  output logic      busy,
  output tx_state_t state
);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t          state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               tick;
  logic               txd_d, busy_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd     <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd     <= txd_d;
      busy    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ready   = 1'b0;
    tick    = (baud_q == BAUD_LAST);
    if (state_q != IDLE) baud_d = tick ? '0 : baud_q + BAUD_W'(1);
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (load) begin
          state_d = START;
          shreg_d = tx_byte;
          baud_d  = '0;
        end
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (tick) begin
        shreg_d = {1'b0, shreg_q[7:1]};
        if (bit_q == 3'd7) begin
          state_d = STOP;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      STOP: if (tick) begin
        // Accepting the next byte here makes consecutive frames gapless.
        ready = 1'b1;
        if (load) begin
          state_d = START;
          shreg_d = tx_byte;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Line and busy are registered from the next state so they align with it.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
  end

  assign state = state_q;
endmodule

// File: rtl/md6_hash_tx.sv
// Returns the MD6 digest over TxD: button sync, digest latch, MSB-first byte sequencing.
module md6_hash_tx
  import md6_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic          clk,
  input  logic          reset,
  md6_hash_tx_if.slave  bus,
  output tx_state_t     state_dbg
);
  localparam logic [9:0] MAX_D_L = 10'(MAX_D);

  logic                  s1, s2, s3, rise, accept;
  seq_state_t            seq_q, seq_d;
  logic [MAX_D-1:0]      store_q, hash_mask;
  logic [BYTE_IDX_W-1:0] byte_idx_q, first_idx;
  logic                  pending_q, done_q;
  logic [9:0]            dc;
  logic                  load, ready;
  logic [7:0]            tx_byte;
  tx_state_t             ser_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.button_tx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Digest bits at or above dc are cleared so the leading byte pads with zeros.
  always_comb begin
    dc        = (bus.d > MAX_D_L) ? MAX_D_L : bus.d;
    first_idx = BYTE_IDX_W'((dc - 10'd1) >> 3);
    for (int j = 0; j < MAX_D; j++) hash_mask[j] = (j < int'(dc));
  end

  always_comb begin
    seq_d  = seq_q;
    load   = 1'b0;
    accept = 1'b0;
    case (seq_q)
      SEQ_IDLE: if (rise && bus.hash_valid && (bus.d != '0)) begin
        accept = 1'b1;
        seq_d  = SEQ_SEND;
      end
      SEQ_SEND: begin
        load = pending_q;
        if (!pending_q && ready) seq_d = SEQ_DONE;
      end
      SEQ_DONE: seq_d = SEQ_IDLE;
      default:  seq_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_q      <= SEQ_IDLE;
      store_q    <= '0;
      byte_idx_q <= '0;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      seq_q  <= seq_d;
      done_q <= (seq_d == SEQ_DONE);
      if (accept) begin
        store_q    <= bus.hash & hash_mask;
        byte_idx_q <= first_idx;
        pending_q  <= 1'b1;
      end else if (load && ready) begin
        if (byte_idx_q == '0) pending_q <= 1'b0;
        else                  byte_idx_q <= byte_idx_q - 1'b1;
      end
    end
  end

  assign tx_byte = store_q[{byte_idx_q, 3'b000} +: 8];

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .tx_byte (tx_byte),
    .ready   (ready),
    .txd     (bus.TxD),
    .busy    (bus.busy),
    .state   (ser_state)
  );

  assign bus.done_tx = done_q;
  assign state_dbg   = (seq_q == SEQ_DONE) ? DONE : ser_state;
endmodule
